// File: rtl/vga_line_fetch.sv
// Ping-pong line buffer between a burst-read frame store and the VGA timing controller.
// While one 640-byte bank is displayed, the next line is fetched into the other bank.
module vga_line_fetch #(
    parameter int H_VALID = 640,
    parameter int V_VALID = 480,
    parameter int ADDR_W  = 19
) (
    input  logic              vga_clk,
    input  logic              sys_rst_n,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    output logic [7:0]        pix_data,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic [7:0]        rd_data,
    input  logic              rd_data_vld,
    output logic              fetch_busy,
    output logic              err
);

    localparam int CNT_W  = $clog2(H_VALID);
    localparam int RAM_AW = $clog2(2 * H_VALID);

    localparam logic [9:0]        H_LIM      = 10'(H_VALID);
    localparam logic [9:0]        V_LIM      = 10'(V_VALID);
    localparam logic [9:0]        V_LAST     = 10'(V_VALID - 1);
    localparam logic [CNT_W-1:0]  BEAT_LAST  = CNT_W'(H_VALID - 1);
    localparam logic [RAM_AW-1:0] BANK1_BASE = RAM_AW'(H_VALID);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RECV
    } state_t;

    state_t              state_q, state_d;
    logic [9:0]          fetch_line_q, fetch_line_d;
    logic [CNT_W-1:0]    beat_q, beat_d;
    logic                rd_req_q, rd_req_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic                start_q, start_d;
    logic                pix_vld_q, pix_vld_d;

    logic                disp_in_range;
    logic                trigger;
    logic                launch;
    logic [9:0]          next_line;
    logic [9:0]          launch_line;
    logic [ADDR_W-1:0]   line_ext;
    logic [ADDR_W-1:0]   line_base;

    logic                wr_en;
    logic [RAM_AW-1:0]   wr_idx;
    logic [RAM_AW-1:0]   rd_idx;
    logic [7:0]          ram_dout;
    logic [7:0]          line_mem [0:2*H_VALID-1];

    assign disp_in_range = (pix_x < H_LIM) && (pix_y < V_LIM);
    assign trigger       = (pix_x == 10'd0) && (pix_y < V_LIM);
    assign next_line     = (pix_y == V_LAST) ? 10'd0 : pix_y + 10'd1;
    // The pending start-up fetch wins over a coincident trigger and always targets line 0.
    assign launch_line   = start_q ? 10'd0 : next_line;
    assign launch        = start_q || trigger;
    assign line_ext      = ADDR_W'(launch_line);

    generate
        if (H_VALID == 640) begin : g_base_shift
            assign line_base = (line_ext << 9) + (line_ext << 7);
        end else begin : g_base_mul
            assign line_base = line_ext * ADDR_W'(H_VALID);
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        fetch_line_d = fetch_line_q;
        beat_d       = beat_q;
        rd_req_d     = rd_req_q;
        rd_addr_d    = rd_addr_q;
        busy_d       = busy_q;
        err_d        = err_q;
        start_d      = start_q;
        pix_vld_d    = disp_in_range;

        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d      = REQ;
                    fetch_line_d = launch_line;
                    rd_addr_d    = line_base;
                    rd_req_d     = 1'b1;
                    busy_d       = 1'b1;
                    start_d      = 1'b0;
                end
            end
            REQ: begin
                if (trigger) begin
                    err_d = 1'b1;
                end
                if (rd_ack) begin
                    state_d  = RECV;
                    rd_req_d = 1'b0;
                    beat_d   = '0;
                end
            end
            RECV: begin
                if (trigger) begin
                    err_d = 1'b1;
                end
                if (rd_data_vld) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == BEAT_LAST) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                rd_req_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            fetch_line_q <= '0;
            beat_q       <= '0;
            rd_req_q     <= 1'b0;
            rd_addr_q    <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            start_q      <= 1'b1;
            pix_vld_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_line_q <= fetch_line_d;
            beat_q       <= beat_d;
            rd_req_q     <= rd_req_d;
            rd_addr_q    <= rd_addr_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            start_q      <= start_d;
            pix_vld_q    <= pix_vld_d;
        end
    end

    // Bank b occupies entries [b*H_VALID, b*H_VALID+H_VALID-1] of one dual-port array.
    assign wr_en  = (state_q == RECV) && rd_data_vld;
    assign wr_idx = (fetch_line_q[0] ? BANK1_BASE : '0) + RAM_AW'(beat_q);
    assign rd_idx = (pix_y[0] ? BANK1_BASE : '0) + RAM_AW'(pix_x);

    always_ff @(posedge vga_clk) begin
        if (wr_en) begin
            line_mem[wr_idx] <= rd_data;
        end
        if (disp_in_range) begin
            ram_dout <= line_mem[rd_idx];
        end
    end

    // RAM output carries no reset; the registered in-range flag forces zero after reset and in blanking.
    assign pix_data   = pix_vld_q ? ram_dout : 8'h00;
    assign rd_req     = rd_req_q;
    assign rd_addr    = rd_addr_q;
    assign fetch_busy = busy_q;
    assign err        = err_q;

endmodule
